stage_write_arb: RTL and testbench

Registered writeback stage for the pipelined processor. It merges two result sources onto the single regfile write port and the rstatus write port: in-order results from the MEM/WB pipeline and out-of-order results from the multicycle mult/div unit. Mult/div results are held in a small FIFO and drain into idle writeback slots. The block also generates exception codes and the rstatus write.

---
 rtl/wb_pkg.sv | 41 ++++
 rtl/wb_fifo.sv | 59 +++++
 rtl/stage_write_arb.sv | 191 +++++++++++++++++++
 tb/tb_stage_write_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage.
//   - opcode / ALU-op encodings decoded at writeback
//   - exception codes reported through the rstatus write
//   - md_entry_t: layout of one pending mult/div result at the default widths
package wb_pkg;

    typedef enum logic [4:0] {
        OP_R    = 5'b00000,
        OP_JAL  = 5'b00011,
        OP_ADDI = 5'b00101,
        OP_LW   = 5'b01000,
        OP_SETX = 5'b10101
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_MUL = 5'b00110,
        ALU_DIV = 5'b00111
    } alu_op_e;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_ADD  = 3'd1,
        EXC_ADDI = 3'd2,
        EXC_SUB  = 3'd3,
        EXC_MUL  = 3'd4,
        EXC_DIV  = 3'd5
    } exc_code_e;

    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_REG_AW = 5;

    typedef struct packed {
        logic [MD_REG_AW-1:0] rd;
        logic [MD_DATA_W-1:0] result;
        logic                 is_div;
        logic                 exc;
    } md_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding pending mult/div results.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wdata  : write request (ignored while full)
//   pop, rdata   : read request (ignored while empty); rdata shows the head
//   count        : registered occupancy, 0..DEPTH
//   full, empty  : decoded from count
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    import wb_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/stage_write_arb.sv
// stage_write_arb: registered writeback stage. Merges in-order MEM/WB results
// and queued mult/div results onto one regfile write port and the rstatus port.
//   clock, reset             : rising-edge clock, async active-high reset
//   wb_valid..exception      : pipeline slot (opcode decode, data sources)
//   md_valid/md_ready/md_*   : mult/div result handshake into the pending FIFO
//   ctrl_writeEnable/Reg, data_writeReg : registered regfile write
//   status_we, data_writeStatusReg      : registered rstatus write
//   md_pending               : FIFO occupancy for the hazard unit
// The pipeline always has priority; mult/div results drain into idle slots.
module stage_write_arb #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned TARGET_W   = 27,
    parameter int unsigned MD_DEPTH   = 4,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned STATUS_REG = 30
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [4:0]                 opcode,
    input  logic [4:0]                 alu_op,
    input  logic [DATA_W-1:0]          o_in,
    input  logic [DATA_W-1:0]          d_in,
    input  logic [REG_AW-1:0]          rd,
    input  logic [DATA_W-1:0]          pc_plus_4,
    input  logic [DATA_W-TARGET_W-1:0] pc_upper,
    input  logic [TARGET_W-1:0]        target,
    input  logic                       exception,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [REG_AW-1:0]          md_rd,
    input  logic [DATA_W-1:0]          md_result,
    input  logic                       md_is_div,
    input  logic                       md_exception,
    output logic                       ctrl_writeEnable,
    output logic [REG_AW-1:0]          ctrl_writeReg,
    output logic [DATA_W-1:0]          data_writeReg,
    output logic                       status_we,
    output logic [DATA_W-1:0]          data_writeStatusReg,
    output logic [$clog2(MD_DEPTH):0]  md_pending
);
    import wb_pkg::*;

    if (MD_DEPTH < 2 || (MD_DEPTH & (MD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("MD_DEPTH must be a power of two >= 2");
    end
    // rstatus lives at STATUS_REG in the architectural file but is written
    // only through the dedicated status port.
    if (STATUS_REG == 0 || STATUS_REG >= (1 << REG_AW)) begin : g_bad_status_reg
        $error("STATUS_REG must be a nonzero register index");
    end

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] result;
        logic              is_div;
        logic              exc;
    } entry_t;

    entry_t push_entry;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;

    logic              pipe_rf_we;
    logic [REG_AW-1:0] pipe_rf_addr;
    logic [DATA_W-1:0] pipe_rf_data;
    logic              pipe_st_we;
    logic [DATA_W-1:0] pipe_st_data;

    logic              nxt_we;
    logic [REG_AW-1:0] nxt_reg;
    logic [DATA_W-1:0] nxt_data;
    logic              nxt_swe;
    logic [DATA_W-1:0] nxt_sdata;

    assign push_entry = '{rd: md_rd, result: md_result, is_div: md_is_div, exc: md_exception};
    assign md_ready   = ~fifo_full;

    wb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (MD_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (md_valid),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .count (md_pending),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pipeline decode.
    always_comb begin
        pipe_rf_we   = 1'b0;
        pipe_rf_addr = rd;
        pipe_rf_data = o_in;
        pipe_st_we   = 1'b0;
        pipe_st_data = '0;
        if (wb_valid) begin
            case (opcode)
                OP_R: begin
                    if (alu_op == ALU_MUL || alu_op == ALU_DIV) begin
                        pipe_rf_we = 1'b0;
                    end else if (exception && alu_op == ALU_ADD) begin
                        pipe_st_we   = 1'b1;
                        pipe_st_data = DATA_W'(EXC_ADD);
                    end else if (exception && alu_op == ALU_SUB) begin
                        pipe_st_we   = 1'b1;
                        pipe_st_data = DATA_W'(EXC_SUB);
                    end else begin
                        pipe_rf_we = 1'b1;
                    end
                end
                OP_ADDI: begin
                    if (exception) begin
                        pipe_st_we   = 1'b1;
                        pipe_st_data = DATA_W'(EXC_ADDI);
                    end else begin
                        pipe_rf_we = 1'b1;
                    end
                end
                OP_LW: begin
                    pipe_rf_we   = 1'b1;
                    pipe_rf_data = d_in;
                end
                OP_JAL: begin
                    pipe_rf_we   = 1'b1;
                    pipe_rf_addr = REG_AW'(LINK_REG);
                    pipe_rf_data = pc_plus_4;
                end
                OP_SETX: begin
                    pipe_st_we   = 1'b1;
                    pipe_st_data = {pc_upper, target};
                end
                default: pipe_rf_we = 1'b0;
            endcase
        end
        // A write to r0 is dropped, so the slot counts as idle for draining.
        if (pipe_rf_addr == '0) pipe_rf_we = 1'b0;
    end

    // Arbitration: pipeline first, otherwise drain the FIFO head.
    always_comb begin
        nxt_we    = 1'b0;
        nxt_reg   = '0;
        nxt_data  = '0;
        nxt_swe   = 1'b0;
        nxt_sdata = '0;
        pop       = 1'b0;
        if (pipe_rf_we) begin
            nxt_we   = 1'b1;
            nxt_reg  = pipe_rf_addr;
            nxt_data = pipe_rf_data;
        end else if (pipe_st_we) begin
            nxt_swe   = 1'b1;
            nxt_sdata = pipe_st_data;
        end else if (!fifo_empty) begin
            pop = 1'b1;
            if (head.exc) begin
                nxt_swe   = 1'b1;
                nxt_sdata = head.is_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MUL);
            end else if (head.rd != '0) begin
                nxt_we   = 1'b1;
                nxt_reg  = head.rd;
                nxt_data = head.result;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_writeEnable    <= 1'b0;
            ctrl_writeReg       <= '0;
            data_writeReg       <= '0;
            status_we           <= 1'b0;
            data_writeStatusReg <= '0;
        end else begin
            ctrl_writeEnable    <= nxt_we;
            ctrl_writeReg       <= nxt_reg;
            data_writeReg       <= nxt_data;
            status_we           <= nxt_swe;
            data_writeStatusReg <= nxt_sdata;
        end
    end

endmodule

// File: tb/tb_stage_write_arb.sv
// Bench for stage_write_arb: directed table, hand sequences for the queue
// corner cases, and randomized traffic against a queue-based reference model.
module tb_stage_write_arb;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  opcode, alu_op, rd, md_rd;
    logic [31:0] o_in, d_in, pc_plus_4, md_result;
    logic [4:0]  pc_upper;
    logic [26:0] target;
    logic        exception, md_valid, md_ready, md_is_div, md_exception;
    logic        ctrl_writeEnable, status_we;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg, data_writeStatusReg;
    logic [2:0]  md_pending;

    stage_write_arb #(
        .DATA_W(32), .REG_AW(5), .TARGET_W(27), .MD_DEPTH(DEPTH),
        .LINK_REG(31), .STATUS_REG(30)
    ) dut (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .opcode(opcode),
        .alu_op(alu_op), .o_in(o_in), .d_in(d_in), .rd(rd),
        .pc_plus_4(pc_plus_4), .pc_upper(pc_upper), .target(target),
        .exception(exception), .md_valid(md_valid), .md_ready(md_ready),
        .md_rd(md_rd), .md_result(md_result), .md_is_div(md_is_div),
        .md_exception(md_exception), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .status_we(status_we), .data_writeStatusReg(data_writeStatusReg),
        .md_pending(md_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wb_valid;
        logic [4:0]  opcode, alu_op, rd;
        logic [31:0] o_in, d_in, pc_plus_4;
        logic [4:0]  pc_upper;
        logic [26:0] target;
        logic        exception;
        logic        md_valid;
        logic [4:0]  md_rd;
        logic [31:0] md_result;
        logic        md_is_div, md_exception;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        swe;
        logic [31:0] sdata;
    } vec_t;

    int checks = 0;
    int errors = 0;
    in_t cur;
    md_entry_t q[$];
    logic        e_we, e_swe;
    logic [4:0]  e_reg;
    logic [31:0] e_data, e_sdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t idle_in();
        in_t v;
        v.wb_valid = 0; v.opcode = 0; v.alu_op = 0; v.rd = 0; v.o_in = 0;
        v.d_in = 0; v.pc_plus_4 = 0; v.pc_upper = 0; v.target = 0;
        v.exception = 0; v.md_valid = 0; v.md_rd = 0; v.md_result = 0;
        v.md_is_div = 0; v.md_exception = 0;
        return v;
    endfunction

    function automatic in_t mk(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] r,
                               input logic [31:0] o, input logic [31:0] d, input logic [31:0] pc4,
                               input logic [4:0] pcu, input logic [26:0] tgt, input logic exc);
        in_t v = idle_in();
        v.wb_valid = 1; v.opcode = op; v.alu_op = alu; v.rd = r; v.o_in = o;
        v.d_in = d; v.pc_plus_4 = pc4; v.pc_upper = pcu; v.target = tgt; v.exception = exc;
        return v;
    endfunction

    function automatic vec_t mv(input string n, input in_t i, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic swe, input logic [31:0] sd);
        vec_t v;
        v.name = n; v.in = i; v.we = we; v.wreg = wr; v.wdata = wd; v.swe = swe; v.sdata = sd;
        return v;
    endfunction

    task automatic apply(input in_t v);
        cur = v;
        wb_valid = v.wb_valid; opcode = v.opcode; alu_op = v.alu_op; rd = v.rd;
        o_in = v.o_in; d_in = v.d_in; pc_plus_4 = v.pc_plus_4; pc_upper = v.pc_upper;
        target = v.target; exception = v.exception; md_valid = v.md_valid;
        md_rd = v.md_rd; md_result = v.md_result; md_is_div = v.md_is_div;
        md_exception = v.md_exception;
    endtask

    // Reference: what the pipeline slot asks to write, from the decode rules.
    function automatic void pipe_model(input in_t v, output logic rf, output logic [4:0] a,
                                       output logic [31:0] d, output logic st, output logic [31:0] sd);
        rf = 0; a = 0; d = 0; st = 0; sd = 0;
        if (v.wb_valid) begin
            if (v.opcode == 5'd0) begin
                if (v.alu_op == 5'd6 || v.alu_op == 5'd7) rf = 0;
                else if (v.exception && v.alu_op == 5'd0) begin st = 1; sd = 1; end
                else if (v.exception && v.alu_op == 5'd1) begin st = 1; sd = 3; end
                else begin rf = 1; a = v.rd; d = v.o_in; end
            end else if (v.opcode == 5'd5) begin
                if (v.exception) begin st = 1; sd = 2; end
                else begin rf = 1; a = v.rd; d = v.o_in; end
            end else if (v.opcode == 5'd8) begin
                rf = 1; a = v.rd; d = v.d_in;
            end else if (v.opcode == 5'd3) begin
                rf = 1; a = 5'd31; d = v.pc_plus_4;
            end else if (v.opcode == 5'd21) begin
                st = 1; sd = {v.pc_upper, v.target};
            end
        end
        if (rf && a == 0) begin rf = 0; a = 0; d = 0; end
    endfunction

    // Advance the reference across one clock edge using the current inputs.
    task automatic model_edge();
        logic rf, st;
        logic [4:0] a;
        logic [31:0] d, sd;
        int old;
        md_entry_t h;
        pipe_model(cur, rf, a, d, st, sd);
        e_we = 0; e_reg = 0; e_data = 0; e_swe = 0; e_sdata = 0;
        old = q.size();
        if (rf) begin e_we = 1; e_reg = a; e_data = d; end
        else if (st) begin e_swe = 1; e_sdata = sd; end
        else if (old > 0) begin
            h = q.pop_front();
            if (h.exc) begin e_swe = 1; e_sdata = h.is_div ? 32'd5 : 32'd4; end
            else if (h.rd != 0) begin e_we = 1; e_reg = h.rd; e_data = h.result; end
        end
        if (cur.md_valid && old < DEPTH) begin
            h.rd = cur.md_rd; h.result = cur.md_result; h.is_div = cur.md_is_div; h.exc = cur.md_exception;
            q.push_back(h);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".we"},      32'(ctrl_writeEnable), 32'(e_we));
        check({tag, ".reg"},     32'(ctrl_writeReg),    32'(e_reg));
        check({tag, ".data"},    data_writeReg,         e_data);
        check({tag, ".swe"},     32'(status_we),        32'(e_swe));
        check({tag, ".sdata"},   data_writeStatusReg,   e_sdata);
        check({tag, ".pending"}, 32'(md_pending),       32'(q.size()));
        check({tag, ".ready"},   32'(md_ready),         32'(q.size() < DEPTH));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        in_t v;
        int dens;

        reset = 1'b1;
        apply(idle_in());
        @(posedge clock);
        #1;
        check("rst.we", 32'(ctrl_writeEnable), 0);
        check("rst.swe", 32'(status_we), 0);
        check("rst.data", data_writeReg, 0);
        check("rst.pending", 32'(md_pending), 0);
        check("rst.ready", 32'(md_ready), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed pipeline decode vectors.
        tbl[0]  = mv("addi",      mk(5, 0, 3, 7, 0, 0, 0, 0, 0),                 1, 3, 7, 0, 0);
        tbl[1]  = mv("add_exc",   mk(0, 0, 4, 9, 0, 0, 0, 0, 1),                 0, 0, 0, 1, 1);
        tbl[2]  = mv("setx",      mk(21, 0, 0, 0, 0, 0, 0, 27'h123, 0),          0, 0, 0, 1, 32'h123);
        tbl[3]  = mv("jal",       mk(3, 0, 0, 0, 0, 32'h40, 0, 0, 0),            1, 31, 32'h40, 0, 0);
        tbl[4]  = mv("lw_r0",     mk(8, 0, 0, 0, 32'h55, 0, 0, 0, 0),            0, 0, 0, 0, 0);
        tbl[5]  = mv("lw",        mk(8, 0, 9, 1, 32'hdeadbeef, 0, 0, 0, 0),      1, 9, 32'hdeadbeef, 0, 0);
        tbl[6]  = mv("sub_exc",   mk(0, 1, 2, 0, 0, 0, 0, 0, 1),                 0, 0, 0, 1, 3);
        tbl[7]  = mv("addi_exc",  mk(5, 0, 2, 0, 0, 0, 0, 0, 1),                 0, 0, 0, 1, 2);
        tbl[8]  = mv("and_exc",   mk(0, 2, 6, 5, 0, 0, 0, 0, 1),                 1, 6, 5, 0, 0);
        tbl[9]  = mv("rmul",      mk(0, 6, 7, 8, 0, 0, 0, 0, 0),                 0, 0, 0, 0, 0);
        tbl[10] = mv("invalid",   mk(5, 0, 3, 7, 0, 0, 0, 0, 0),                 0, 0, 0, 0, 0);
        tbl[10].in.wb_valid = 0;
        tbl[11] = mv("setx_max",  mk(21, 0, 0, 0, 0, 0, 5'h1f, 27'h7ffffff, 0),  0, 0, 0, 1, 32'hffffffff);
        tbl[12] = mv("bad_op",    mk(2, 0, 3, 7, 0, 0, 0, 0, 0),                 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].in);
            tick();
            check({tbl[i].name, ".we"},    32'(ctrl_writeEnable), 32'(tbl[i].we));
            check({tbl[i].name, ".reg"},   32'(ctrl_writeReg),    32'(tbl[i].wreg));
            check({tbl[i].name, ".data"},  data_writeReg,         tbl[i].wdata);
            check({tbl[i].name, ".swe"},   32'(status_we),        32'(tbl[i].swe));
            check({tbl[i].name, ".sdata"}, data_writeStatusReg,   tbl[i].sdata);
        end

        // Fill the FIFO while the pipeline writes every cycle.
        for (int i = 0; i < 4; i++) begin
            v = mk(5, 0, 1, 32'(i), 0, 0, 0, 0, 0);
            v.md_valid = 1; v.md_rd = 5'(5 + i); v.md_result = 32'(100 + i);
            apply(v);
            tick();
            check_all("fill");
        end
        check("full.ready", 32'(md_ready), 0);
        check("full.pending", 32'(md_pending), 4);
        // Offer while full and busy: ignored.
        v.md_rd = 5'd9; v.md_result = 32'd999;
        apply(v);
        tick();
        check("full_busy.pending", 32'(md_pending), 4);
        check("full_busy.ready", 32'(md_ready), 0);
        // Pipeline idles: drain in order on consecutive cycles.
        apply(idle_in());
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain.we", 32'(ctrl_writeEnable), 1);
            check("drain.reg", 32'(ctrl_writeReg), 32'(5 + i));
            check("drain.data", data_writeReg, 32'(100 + i));
            if (i == 0) check("drain.ready_back", 32'(md_ready), 1);
            check_all("drain");
        end

        // Full FIFO, pipeline idle, offer: pop happens, push ignored; then push+pop holds count.
        for (int i = 0; i < 4; i++) begin
            v = mk(8, 0, 2, 0, 32'(i), 0, 0, 0, 0);
            v.md_valid = 1; v.md_rd = 5'(12 + i); v.md_result = 32'(200 + i);
            apply(v);
            tick();
        end
        v = idle_in(); v.md_valid = 1; v.md_rd = 5'd20; v.md_result = 32'd300;
        apply(v);
        tick();
        check("full_idle.pending", 32'(md_pending), 3);
        check_all("full_idle");
        tick();
        check("pushpop.pending", 32'(md_pending), 3);
        check_all("pushpop");
        apply(idle_in());
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("drain2");
        end

        // Div exception entry: no output after push, status code 5 a cycle later.
        v = idle_in(); v.md_valid = 1; v.md_rd = 5'd10; v.md_is_div = 1; v.md_exception = 1;
        apply(v);
        tick();
        check("divexc.lat_we", 32'(ctrl_writeEnable), 0);
        check("divexc.lat_swe", 32'(status_we), 0);
        check("divexc.lat_pending", 32'(md_pending), 1);
        apply(idle_in());
        tick();
        check("divexc.swe", 32'(status_we), 1);
        check("divexc.sdata", data_writeStatusReg, 5);
        check("divexc.we", 32'(ctrl_writeEnable), 0);
        check_all("divexc");

        // Reset mid-cycle with three results pending.
        for (int i = 0; i < 3; i++) begin
            v = mk(5, 0, 3, 32'(i), 0, 0, 0, 0, 0);
            v.md_valid = 1; v.md_rd = 5'(20 + i); v.md_result = 32'(400 + i);
            apply(v);
            tick();
        end
        check("prerst.pending", 32'(md_pending), 3);
        apply(idle_in());
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check("asyncrst.we", 32'(ctrl_writeEnable), 0);
        check("asyncrst.data", data_writeReg, 0);
        check("asyncrst.pending", 32'(md_pending), 0);
        check("asyncrst.ready", 32'(md_ready), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        check("postrst.we", 32'(ctrl_writeEnable), 0);
        check("postrst.swe", 32'(status_we), 0);
        check_all("postrst");
        tick();
        check_all("postrst2");

        // Randomized traffic with varying pipeline density.
        dens = 50;
        for (int n = 0; n < 2000; n++) begin
            if (n % 200 == 0) dens = $urandom_range(0, 100);
            v = idle_in();
            v.wb_valid = ($urandom_range(0, 99) < dens);
            case ($urandom_range(0, 5))
                0: v.opcode = 5'd0;
                1: v.opcode = 5'd5;
                2: v.opcode = 5'd8;
                3: v.opcode = 5'd3;
                4: v.opcode = 5'd21;
                default: v.opcode = 5'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: v.alu_op = 5'd0;
                1: v.alu_op = 5'd1;
                2: v.alu_op = 5'd6;
                3: v.alu_op = 5'd7;
                default: v.alu_op = 5'($urandom);
            endcase
            v.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            v.o_in = $urandom; v.d_in = $urandom; v.pc_plus_4 = $urandom;
            v.pc_upper = 5'($urandom); v.target = 27'($urandom);
            v.exception = ($urandom_range(0, 3) == 0);
            v.md_valid = $urandom_range(0, 1);
            v.md_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            v.md_result = $urandom;
            v.md_is_div = $urandom_range(0, 1);
            v.md_exception = ($urandom_range(0, 3) == 0);
            apply(v);
            tick();
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
